// File: rtl/aes_pipe_checker.sv
// Response checker for pipelined AES cores: ages each pushed vector through a LATENCY-deep
// valid pipeline and compares the core output against the queued expected value on maturity.
module aes_pipe_checker #(
  parameter int unsigned WIDTH   = 128,
  parameter int unsigned LATENCY = 20,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             exp_valid,
  input  logic [WIDTH-1:0] exp_data,
  input  logic [WIDTH-1:0] dut_out,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic             ovf,
  output logic             idle,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_got
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [LATENCY-1:0] pipe_q, pipe_d;
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic               err_q, err_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   ff_idx_q, ff_idx_d;
  logic [WIDTH-1:0]   ff_got_q, ff_got_d;

  logic [WIDTH-1:0]   data_mem_q [DEPTH];
  logic [CNT_W-1:0]   idx_mem_q  [DEPTH];

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             match;
  logic [WIDTH-1:0] head_data;
  logic [CNT_W-1:0] head_idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Extra pointer MSB distinguishes full from empty when the index bits coincide.
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);

  assign push      = exp_valid & ~full & ~clear;
  assign pop       = pipe_q[LATENCY-1] & ~empty & ~clear;
  assign head_data = data_mem_q[rptr_q[AW-1:0]];
  assign head_idx  = idx_mem_q[rptr_q[AW-1:0]];
  assign match     = (dut_out == head_data);

  always_comb begin
    pipe_d     = pipe_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    vec_cnt_d  = vec_cnt_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    ff_idx_d   = ff_idx_q;
    ff_got_d   = ff_got_q;

    if (clear) begin
      pipe_d     = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      vec_cnt_d  = '0;
      pass_cnt_d = '0;
      fail_cnt_d = '0;
      err_d      = 1'b0;
      ovf_d      = 1'b0;
      ff_idx_d   = '0;
      ff_got_d   = '0;
    end else begin
      pipe_d = (pipe_q << 1) | LATENCY'(push);

      if (push) begin
        wptr_d    = wptr_q + PW'(1);
        vec_cnt_d = sat_inc(vec_cnt_q);
      end
      if (exp_valid && full) begin
        ovf_d = 1'b1;
      end

      if (pop) begin
        rptr_d = rptr_q + PW'(1);
        if (match) begin
          pass_cnt_d = sat_inc(pass_cnt_q);
        end else begin
          fail_cnt_d = sat_inc(fail_cnt_q);
          err_d      = 1'b1;
          // err_q still low means this is the first mismatch since reset/clear.
          if (!err_q) begin
            ff_idx_d = head_idx;
            ff_got_d = dut_out;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      vec_cnt_q  <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      ff_idx_q   <= '0;
      ff_got_q   <= '0;
    end else begin
      pipe_q     <= pipe_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      vec_cnt_q  <= vec_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      ff_idx_q   <= ff_idx_d;
      ff_got_q   <= ff_got_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wptr_q[AW-1:0]] <= exp_data;
      idx_mem_q[wptr_q[AW-1:0]]  <= vec_cnt_q;
    end
  end

  assign vec_cnt        = vec_cnt_q;
  assign pass_cnt       = pass_cnt_q;
  assign fail_cnt       = fail_cnt_q;
  assign err            = err_q;
  assign ovf            = ovf_q;
  assign idle           = ~(|pipe_q) & empty;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_got = ff_got_q;

endmodule

// File: doc/aes_pipe_checker.md
Name: aes_pipe_checker

Overview:
- Synthesizable, self-checking response checker for pipelined AES cores of arbitrary latency and width.
- Alongside each input vector, the driver pushes the expected result.
- The block ages each token through a LATENCY-deep valid pipeline and queues expected values in a FIFO.
- When a token matures, it compares the core output against the queued value and keeps pass/fail counters, sticky flags and first-failure capture.
- Sits beside the AES core in on-chip BIST and FPGA regression harnesses, replacing per-vector hard-coded checks.

Parameters:
- WIDTH, 128: data width of expected and DUT output words.
- LATENCY, 20: rising edges from input sample to valid DUT output. Range 1..255.
- DEPTH, 32: expected-value FIFO entries. Power of two, and DEPTH >= LATENCY.
- CNT_W, 16: width of the vector, pass and fail counters.

Ports:
- clk, in, 1: single clock; all state updates on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- clear, in, 1: synchronous clear of all state, same effect as reset.
- exp_valid, in, 1: an input vector enters the DUT this edge; exp_data is its expected result.
- exp_data, in, WIDTH: expected DUT output for this vector.
- dut_out, in, WIDTH: DUT output bus.
- vec_cnt, out, CNT_W: vectors accepted.
- pass_cnt, out, CNT_W: matured vectors that matched.
- fail_cnt, out, CNT_W: matured vectors that mismatched.
- err, out, 1: sticky; set on any mismatch.
- ovf, out, 1: sticky; set on a push while the FIFO is full.
- idle, out, 1: no tokens in flight.
- first_fail_idx, out, CNT_W: vector index (0-based) of the first mismatch.
- first_fail_got, out, WIDTH: dut_out captured at the first mismatch.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All counters, err, ovf, first_fail_idx and first_fail_got go to 0.
  - idle goes to 1.
  - FIFO pointers and the valid pipeline are emptied.
- clear=1 at an edge: identical result to reset, applied synchronously.
  - clear has priority over exp_valid and over maturing tokens in the same cycle; both are discarded without counting.
- Accept (exp_valid=1, FIFO not full, clear=0):
  - Write exp_data at the FIFO write pointer.
  - Shift a 1 into valid-pipeline stage 0.
  - Record the vector index (vec_cnt value before increment) alongside the data.
  - vec_cnt increments.
- Accept with FIFO full:
  - Data dropped, no token enters the pipeline, vec_cnt unchanged, ovf set.
  - Unreachable when DEPTH >= LATENCY; covered for robustness.
- Valid pipeline:
  - LATENCY-bit shift register, shifting every cycle.
  - A token accepted at edge T matures at edge T+LATENCY.
  - At that edge the checker compares the FIFO head with the dut_out value sampled on that same edge.
- Maturity and compare:
  - The FIFO pops the head.
  - Match (all WIDTH bits equal): pass_cnt increments.
  - Mismatch: fail_cnt increments and err is set.
  - If this is the first mismatch since reset/clear, first_fail_idx takes the head's index and first_fail_got takes dut_out. Later mismatches do not overwrite these.
- Simultaneous accept and maturity in one cycle: push and pop both occur; occupancy is unchanged.
- Back-to-back accepts every cycle are supported indefinitely with no bubbles.
- Counters saturate at all-ones and do not wrap. Saturation of vec_cnt does not block accepts.
- idle = 1 when the valid pipeline is all zero and the FIFO is empty. It is registered-state derived with no combinational path from inputs.
- All outputs are registers or decode of registered state.
- There is no combinational path from exp_valid or dut_out to any output.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally; full and empty come from MSB/index comparison.

Test Plan:
- Reset then idle → all counters 0, err=0, ovf=0, idle=1. Pulsing rst_n low mid-stream with 5 tokens in flight returns every output to its reset value immediately.
- LATENCY=20, aes_128 DUT. Push 5 vectors on consecutive edges, each paired with its correct result:
  - state 3243f6a8885a308d313198a2e0370734 with key 2b7e151628aed2a6abf7158809cf4f3c, expected 3925841d02dc09fbdc118597196a0b32.
  - Then the FIPS-197 vector 00112233...eeff / 000102...0f, expected 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Then three further vectors with expected 66e94bd4..., 0545aad5..., 58e2fcce....
  - Response: pass_cnt=5, fail_cnt=0, err=0, and idle returns to 1 exactly 20 edges after the last push.
- Same stream with vector 2's expected value corrupted (LSB flipped) → fail_cnt=1, pass_cnt=4, err=1, first_fail_idx=2, first_fail_got=66e94bd4ef8a2c3b884cfa59ca342b2e.
- Two corrupted vectors (idx 1 and 3) → fail_cnt=2, first_fail_idx=1 (not overwritten).
- Assert clear on the same edge as exp_valid while 3 tokens are in flight → vec_cnt=0, FIFO empty, no subsequent compares, idle=1 next cycle.
- Build with DEPTH=4, LATENCY=8 (illegal sizing) and push 6 consecutive vectors → vec_cnt=4, ovf=1, exactly 4 compares performed.
